// File: rtl/ysyx_wbu_queue_if.sv
// EXU-to-write-back handshake bundle: one completed instruction per transfer.
`timescale 1ns/1ps
interface ysyx_wbu_queue_if #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
);
  logic              prev_valid;
  logic              ready_o;
  logic [XLEN-1:0]   pc_i;
  logic [31:0]       inst_i;
  logic [RIDX_W-1:0] rd_i;
  logic [XLEN-1:0]   wdata_i;
  logic              wen_i;
  logic              ebreak_i;

  // EXU side offers entries and observes back-pressure.
  modport master (
    output prev_valid, pc_i, inst_i, rd_i, wdata_i, wen_i, ebreak_i,
    input  ready_o
  );

  // Write-back queue side.
  modport slave (
    input  prev_valid, pc_i, inst_i, rd_i, wdata_i, wen_i, ebreak_i,
    output ready_o
  );
endinterface

// File: rtl/ysyx_wbu_queue.sv
// Write-back queue: buffers up to DEPTH completed instructions in program
// order, retires one per cycle into the register file, tracks the last
// retired PC and a retire counter, and halts for good on a retired ebreak.
`timescale 1ns/1ps
module ysyx_wbu_queue #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int RIDX_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_wbu_queue_if.slave            up,
  input  logic                       flush_i,
  input  logic                       next_ready,
  output logic                       valid_o,
  output logic                       rf_wen_o,
  output logic [RIDX_W-1:0]          rf_waddr_o,
  output logic [XLEN-1:0]            rf_wdata_o,
  output logic [31:0]                inst_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [CNT_W-1:0]           retired_cnt_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       halt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage, one array per field.
  logic [XLEN-1:0]   pc_q    [DEPTH];
  logic [31:0]       inst_q  [DEPTH];
  logic [RIDX_W-1:0] rd_q    [DEPTH];
  logic [XLEN-1:0]   wdata_q [DEPTH];
  logic              wen_q   [DEPTH];
  logic              ebreak_q[DEPTH];

  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              halt;
  logic [XLEN-1:0]   last_pc;
  logic [CNT_W-1:0]  retired_cnt;

  logic              full;
  logic              ready;
  logic              push;
  logic              pop;
  logic              ebreak_fire;

  // A full queue refuses new entries even if the head leaves this cycle,
  // so ready never depends on the commit side.
  assign full        = (count == CW'(DEPTH));
  assign ready       = ~full & ~halt & ~flush_i;
  assign valid_o     = (count != '0) & ~halt;
  assign push        = up.prev_valid & ready;
  assign pop         = valid_o & next_ready;
  // Edge at which a retiring ebreak is observed; simulation hooks attach here.
  assign ebreak_fire = pop & ebreak_q[rd_ptr];

  assign up.ready_o    = ready;
  assign rf_waddr_o    = rd_q[rd_ptr];
  assign rf_wdata_o    = wdata_q[rd_ptr];
  assign inst_o        = inst_q[rd_ptr];
  assign rf_wen_o      = pop & wen_q[rd_ptr] & (rd_q[rd_ptr] != '0);
  assign pc_o          = last_pc;
  assign retired_cnt_o = retired_cnt;
  assign count_o       = count;
  assign halt_o        = halt;

  // Entry write on accept; payload needs no reset since count gates it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]     <= up.pc_i;
      inst_q[wr_ptr]   <= up.inst_i;
      rd_q[wr_ptr]     <= up.rd_i;
      wdata_q[wr_ptr]  <= up.wdata_i;
      wen_q[wr_ptr]    <= up.wen_i;
      ebreak_q[wr_ptr] <= up.ebreak_i;
    end
  end

  // Pointers, occupancy, retire bookkeeping and the sticky halt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      halt        <= 1'b0;
      last_pc     <= '0;
      retired_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        last_pc     <= pc_q[rd_ptr];
        retired_cnt <= retired_cnt + 1'b1;
      end
      // A retired ebreak or a flush empties the queue; the head that retires
      // alongside a flush has already been accounted for above.
      if (ebreak_fire) begin
        halt  <= 1'b1;
        count <= '0;
      end else if (flush_i) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_wbu_queue.sv
// Scenario bench for ysyx_wbu_queue with a queue-based reference model.
`timescale 1ns/1ps
module tb_ysyx_wbu_queue;
  localparam int XLEN = 32, DEPTH = 4, RIDX_W = 5, CNT_W = 32;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk, rst, flush_i, next_ready;
  logic valid_o, rf_wen_o, halt_o;
  logic [RIDX_W-1:0] rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o, pc_o;
  logic [31:0] inst_o;
  logic [CNT_W-1:0] retired_cnt_o;
  logic [CW-1:0] count_o;

  ysyx_wbu_queue_if #(.XLEN(XLEN), .RIDX_W(RIDX_W)) up ();

  ysyx_wbu_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RIDX_W(RIDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .up(up), .flush_i(flush_i), .next_ready(next_ready),
    .valid_o(valid_o), .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .inst_o(inst_o), .pc_o(pc_o),
    .retired_cnt_o(retired_cnt_o), .count_o(count_o), .halt_o(halt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc; logic [31:0] inst; logic [4:0] rd;
    logic [31:0] wdata; logic wen; logic ebreak;
  } ent_t;

  ent_t mq[$];
  logic [36:0] exp_wr[$], obs_wr[$];
  logic [31:0] m_pc, m_cnt;
  bit m_halt, m_ready, m_valid, m_rfwen, m_has_head;
  ent_t m_head;
  logic o_ready, o_valid, o_rfwen;
  logic [4:0] o_waddr; logic [31:0] o_wdata, o_inst;
  int n_vec = 0, n_err = 0;
  ent_t idle = '0;

  function automatic ent_t mk(logic [31:0] pc, logic [31:0] inst, logic [4:0] rd,
                              logic [31:0] wdata, logic wen, logic eb);
    ent_t e;
    e.pc = pc; e.inst = inst; e.rd = rd; e.wdata = wdata; e.wen = wen; e.ebreak = eb;
    return e;
  endfunction

  function automatic ent_t rnd_ent(int eb_chance);
    return mk({$urandom_range(32'h0fff_ffff), 2'b00} | 32'h8000_0000, $urandom(),
              5'($urandom_range(31)), $urandom(), 1'($urandom_range(1)),
              ($urandom_range(eb_chance - 1) == 0));
  endfunction

  // One clock: drive, sample mid-cycle, advance model at the edge.
  task automatic step(input bit pv, input ent_t e, input bit nr, input bit fl);
    ent_t h;
    bit pop, push;
    h = '0;
    up.prev_valid = pv; up.pc_i = e.pc; up.inst_i = e.inst; up.rd_i = e.rd;
    up.wdata_i = e.wdata; up.wen_i = e.wen; up.ebreak_i = e.ebreak;
    next_ready = nr; flush_i = fl;
    #3;
    m_ready = (mq.size() < DEPTH) && !m_halt && !fl;
    m_valid = (mq.size() != 0) && !m_halt;
    m_has_head = (mq.size() != 0);
    m_head = m_has_head ? mq[0] : '0;
    pop = m_valid && nr;
    push = pv && m_ready;
    m_rfwen = pop && m_head.wen && (m_head.rd != 0);
    if (m_rfwen) exp_wr.push_back({m_head.rd, m_head.wdata});
    o_ready = up.ready_o; o_valid = valid_o; o_rfwen = rf_wen_o;
    o_waddr = rf_waddr_o; o_wdata = rf_wdata_o; o_inst = inst_o;
    if (rf_wen_o === 1'b1) obs_wr.push_back({rf_waddr_o, rf_wdata_o});
    @(posedge clk);
    if (pop) begin h = mq.pop_front(); m_pc = h.pc; m_cnt = m_cnt + 1; end
    if (push) mq.push_back(e);
    if (pop && h.ebreak) begin m_halt = 1; mq.delete(); end
    else if (fl) mq.delete();
    #1;
  endtask

  task automatic do_reset(input bit pv, input bit nr);
    up.prev_valid = pv; next_ready = nr; flush_i = 0; rst = 0;
    @(posedge clk); #1;
    rst = 1;
    mq.delete(); exp_wr.delete(); obs_wr.delete();
    m_pc = 0; m_cnt = 0; m_halt = 0;
  endtask

  task automatic test_reset();
    do_reset(1, 1);
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0h want=0", valid_o); end
    n_vec++; if (up.ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0h want=1", up.ready_o); end
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL reset_count got=%0h want=0", count_o); end
    n_vec++; if (pc_o !== '0) begin n_err++; $display("FAIL reset_pc got=%0h want=0", pc_o); end
    n_vec++; if (retired_cnt_o !== '0) begin n_err++; $display("FAIL reset_cnt got=%0h want=0", retired_cnt_o); end
    n_vec++; if (halt_o !== 1'b0) begin n_err++; $display("FAIL reset_halt got=%0h want=0", halt_o); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] want [3];
    want[0] = {5'd1, 32'h11}; want[1] = {5'd2, 32'h22}; want[2] = {5'd3, 32'h33};
    do_reset(0, 0);
    step(1, mk(32'h8000_0000, 32'h13, 1, 32'h11, 1, 0), 1, 0);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_early got=%0h want=0", o_valid); end
    n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid_rise got=%0h want=1", valid_o); end
    step(1, mk(32'h8000_0004, 32'h13, 2, 32'h22, 1, 0), 1, 0);
    step(1, mk(32'h8000_0008, 32'h13, 3, 32'h33, 1, 0), 1, 0);
    repeat (3) step(0, idle, 1, 0);
    n_vec++; if (obs_wr.size() !== 3) begin n_err++; $display("FAIL b2b_nwrites got=%0d want=3", obs_wr.size()); end
    for (int i = 0; i < 3 && i < obs_wr.size(); i++) begin
      n_vec++; if (obs_wr[i] !== want[i]) begin n_err++; $display("FAIL b2b_write%0d got=%0h want=%0h", i, obs_wr[i], want[i]); end
    end
    n_vec++; if (pc_o !== 32'h8000_0008) begin n_err++; $display("FAIL b2b_pc got=%0h want=80000008", pc_o); end
    n_vec++; if (retired_cnt_o !== 3) begin n_err++; $display("FAIL b2b_cnt got=%0d want=3", retired_cnt_o); end
    n_vec++; if (count_o !== 0) begin n_err++; $display("FAIL b2b_count got=%0d want=0", count_o); end
  endtask

  task automatic test_backpressure();
    ent_t e5;
    do_reset(0, 0);
    for (int i = 0; i < DEPTH; i++)
      step(1, mk(32'h8000_1000 + 4 * i, $urandom(), 5'(i + 1), $urandom(), 1, 0), 0, 0);
    n_vec++; if (count_o !== CW'(DEPTH)) begin n_err++; $display("FAIL bp_full got=%0d want=%0d", count_o, DEPTH); end
    e5 = mk(32'h8000_1010, 32'h13, 9, 32'h55, 1, 0);
    step(1, e5, 0, 0);
    n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got=%0h want=0", o_ready); end
    n_vec++; if (count_o !== CW'(DEPTH)) begin n_err++; $display("FAIL bp_fifth got=%0d want=%0d", count_o, DEPTH); end
    step(1, e5, 1, 0);
    n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_pop got=%0h want=0", o_ready); end
    n_vec++; if (count_o !== CW'(DEPTH - 1)) begin n_err++; $display("FAIL bp_pop got=%0d want=%0d", count_o, DEPTH - 1); end
    step(1, e5, 0, 0);
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_again got=%0h want=1", o_ready); end
    n_vec++; if (count_o !== CW'(DEPTH)) begin n_err++; $display("FAIL bp_accept got=%0d want=%0d", count_o, DEPTH); end
    repeat (DEPTH + 2) step(0, idle, 1, 0);
    n_vec++; if (obs_wr.size() !== exp_wr.size()) begin n_err++; $display("FAIL bp_nwrites got=%0d want=%0d", obs_wr.size(), exp_wr.size()); end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      n_vec++; if (obs_wr[i] !== exp_wr[i]) begin n_err++; $display("FAIL bp_write%0d got=%0h want=%0h", i, obs_wr[i], exp_wr[i]); end
    end
    n_vec++; if (pc_o !== 32'h8000_1010) begin n_err++; $display("FAIL bp_pc got=%0h want=80001010", pc_o); end
    n_vec++; if (retired_cnt_o !== DEPTH + 1) begin n_err++; $display("FAIL bp_cnt got=%0d want=%0d", retired_cnt_o, DEPTH + 1); end
  endtask

  task automatic test_x0_write();
    do_reset(0, 0);
    step(1, mk(32'h8000_0100, 32'h13, 0, 32'hdead, 1, 0), 1, 0);
    step(0, idle, 1, 0);
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL x0_valid got=%0h want=1", o_valid); end
    n_vec++; if (o_rfwen !== 1'b0) begin n_err++; $display("FAIL x0_wen got=%0h want=0", o_rfwen); end
    n_vec++; if (retired_cnt_o !== 1) begin n_err++; $display("FAIL x0_cnt got=%0d want=1", retired_cnt_o); end
    n_vec++; if (pc_o !== 32'h8000_0100) begin n_err++; $display("FAIL x0_pc got=%0h want=80000100", pc_o); end
  endtask

  task automatic test_ebreak();
    do_reset(0, 0);
    step(1, mk(32'h8000_0200, 32'h13, 5, 32'haa, 1, 0), 0, 0);
    step(1, mk(32'h8000_0204, 32'h0010_0073, 0, 32'h0, 0, 1), 0, 0);
    step(1, mk(32'h8000_0208, 32'h13, 6, 32'hcc, 1, 0), 0, 0);
    step(0, idle, 1, 0);
    step(0, idle, 1, 0);
    n_vec++; if (halt_o !== 1'b1) begin n_err++; $display("FAIL eb_halt got=%0h want=1", halt_o); end
    n_vec++; if (count_o !== 0) begin n_err++; $display("FAIL eb_count got=%0d want=0", count_o); end
    n_vec++; if (pc_o !== 32'h8000_0204) begin n_err++; $display("FAIL eb_pc got=%0h want=80000204", pc_o); end
    repeat (3) step(1, rnd_ent(1000), 1, 0);
    n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL eb_ready got=%0h want=0", o_ready); end
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL eb_valid got=%0h want=0", o_valid); end
    n_vec++; if (retired_cnt_o !== 2) begin n_err++; $display("FAIL eb_cnt got=%0d want=2", retired_cnt_o); end
    n_vec++; if (obs_wr.size() !== 1) begin n_err++; $display("FAIL eb_nwrites got=%0d want=1", obs_wr.size()); end
  endtask

  task automatic test_flush();
    do_reset(0, 0);
    for (int i = 0; i < 3; i++)
      step(1, mk(32'h8000_0300 + 4 * i, 32'h13, 5'(7 + i), 32'h70 + i, 1, 0), 0, 0);
    step(1, mk(32'h8000_0400, 32'h13, 1, 32'h1, 1, 0), 1, 1);
    n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready got=%0h want=0", o_ready); end
    n_vec++; if (o_rfwen !== 1'b1) begin n_err++; $display("FAIL fl_wen got=%0h want=1", o_rfwen); end
    n_vec++; if (retired_cnt_o !== 1) begin n_err++; $display("FAIL fl_cnt got=%0d want=1", retired_cnt_o); end
    n_vec++; if (count_o !== 0) begin n_err++; $display("FAIL fl_count got=%0d want=0", count_o); end
    n_vec++; if (pc_o !== 32'h8000_0300) begin n_err++; $display("FAIL fl_pc got=%0h want=80000300", pc_o); end
    step(0, idle, 1, 0);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got=%0h want=0", o_valid); end
    n_vec++; if (retired_cnt_o !== 1) begin n_err++; $display("FAIL fl_cnt_after got=%0d want=1", retired_cnt_o); end
  endtask

  task automatic test_reset_mid();
    do_reset(0, 0);
    for (int i = 0; i < 3; i++) step(1, rnd_ent(1000), 0, 0);
    step(0, idle, 1, 0);
    do_reset(1, 1);
    n_vec++; if (count_o !== 0) begin n_err++; $display("FAIL rm_count got=%0d want=0", count_o); end
    n_vec++; if (retired_cnt_o !== 0) begin n_err++; $display("FAIL rm_cnt got=%0d want=0", retired_cnt_o); end
    n_vec++; if (pc_o !== 0) begin n_err++; $display("FAIL rm_pc got=%0h want=0", pc_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rm_valid got=%0h want=0", valid_o); end
    step(1, mk(32'h8000_0500, 32'h0010_0073, 0, 0, 0, 1), 0, 0);
    step(1, rnd_ent(1000), 0, 0);
    step(1, rnd_ent(1000), 1, 0);
    n_vec++; if (halt_o !== 1'b1) begin n_err++; $display("FAIL rm_halt_pre got=%0h want=1", halt_o); end
    do_reset(0, 1);
    n_vec++; if (halt_o !== 1'b0) begin n_err++; $display("FAIL rm_halt got=%0h want=0", halt_o); end
    n_vec++; if (up.ready_o !== 1'b1) begin n_err++; $display("FAIL rm_ready got=%0h want=1", up.ready_o); end
    n_vec++; if (retired_cnt_o !== 0) begin n_err++; $display("FAIL rm_cnt2 got=%0d want=0", retired_cnt_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] data [2*DEPTH+1];
    do_reset(0, 0);
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      data[i] = $urandom();
      step(1, mk(32'h8000_0600 + 4 * i, $urandom(), 5'(i + 1), data[i], 1, 0), (i % 3) != 0, 0);
    end
    repeat (2 * DEPTH) step(0, idle, 1, 0);
    n_vec++; if (obs_wr.size() !== 2 * DEPTH + 1) begin n_err++; $display("FAIL wrap_n got=%0d want=%0d", obs_wr.size(), 2 * DEPTH + 1); end
    for (int i = 0; i < obs_wr.size() && i < 2 * DEPTH + 1; i++) begin
      n_vec++; if (obs_wr[i] !== {5'(i + 1), data[i]}) begin n_err++; $display("FAIL wrap_data%0d got=%0h want=%0h", i, obs_wr[i], {5'(i + 1), data[i]}); end
    end
    n_vec++; if (retired_cnt_o !== 2 * DEPTH + 1) begin n_err++; $display("FAIL wrap_cnt got=%0d want=%0d", retired_cnt_o, 2 * DEPTH + 1); end
  endtask

  task automatic test_random();
    do_reset(0, 0);
    for (int c = 0; c < 800; c++) begin
      if (m_halt && $urandom_range(3) == 0) do_reset(0, 0);
      step($urandom_range(9) < 6, rnd_ent(40), $urandom_range(1), $urandom_range(19) == 0);
      n_vec++; if ({o_ready, o_valid, o_rfwen} !== {m_ready, m_valid, m_rfwen}) begin
        n_err++; $display("FAIL rnd_hs c=%0d got=%b want=%b", c, {o_ready, o_valid, o_rfwen}, {m_ready, m_valid, m_rfwen}); end
      if (m_has_head) begin
        n_vec++; if ({o_waddr, o_wdata, o_inst} !== {m_head.rd, m_head.wdata, m_head.inst}) begin
          n_err++; $display("FAIL rnd_head c=%0d got=%0h want=%0h", c, {o_waddr, o_wdata, o_inst}, {m_head.rd, m_head.wdata, m_head.inst}); end
      end
      n_vec++; if ({count_o, pc_o, retired_cnt_o, halt_o} !== {CW'(mq.size()), m_pc, m_cnt, m_halt}) begin
        n_err++; $display("FAIL rnd_state c=%0d got=%0h want=%0h", c, {count_o, pc_o, retired_cnt_o, halt_o}, {CW'(mq.size()), m_pc, m_cnt, m_halt}); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 0; flush_i = 0; next_ready = 0;
    up.prev_valid = 0; up.pc_i = 0; up.inst_i = 0; up.rd_i = 0;
    up.wdata_i = 0; up.wen_i = 0; up.ebreak_i = 0;
    m_pc = 0; m_cnt = 0; m_halt = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_x0_write();
    test_ebreak();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
